// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES (FIPS-197) definitions for the iterative cipher core.
//   - state_t / word_t : big-endian 128-bit state and 32-bit word types
//                        (bit 0 is the MSB, byte k = bits 8k..8k+7)
//   - phase_e          : what the core does on the current clock of a pass
//   - SBOX / INV_SBOX  : forward and inverse substitution tables
//   - RCON             : key-schedule round constants
//   - xtime, gmul      : GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1 (0x11B)
//   - sub_word, rot_word and the whole-state round transforms
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef logic [0:127] state_t;
  typedef logic [0:31]  word_t;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_FIRST,
    PH_ROUND,
    PH_FINAL
  } phase_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Multiply by x, reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic word_t sub_word(input word_t w);
    word_t o;
    for (int k = 0; k < 4; k++) o[8*k +: 8] = SBOX[w[8*k +: 8]];
    return o;
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[8:31], w[0:7]};
  endfunction

  function automatic state_t sub_bytes(input state_t s);
    state_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = SBOX[s[8*k +: 8]];
    return o;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
    return o;
  endfunction

  // Row r rotates left by r columns: out(r,c) = in(r, (c+r) mod 4).
  function automatic state_t shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r + 4*c) +: 8] = s[8*(r + 4*((c + r) % 4)) +: 8];
    return o;
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r + 4*((c + r) % 4)) +: 8] = s[8*(r + 4*c) +: 8];
    return o;
  endfunction

  function automatic state_t mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
      o[32*c + 8  +: 8] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
      o[32*c + 16 +: 8] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
      o[32*c + 24 +: 8] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
    end
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c      +: 8];
      a1 = s[32*c + 8  +: 8];
      a2 = s[32*c + 16 +: 8];
      a3 = s[32*c + 24 +: 8];
      o[32*c      +: 8] = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
      o[32*c + 8  +: 8] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
      o[32*c + 16 +: 8] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
      o[32*c + 24 +: 8] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_cipher_core_if.sv
// ---------------------------------------------------------------------------
// aes_cipher_core_if
// Bundles the data side of one aes_cipher_core instance so a parent block
// can route text/key as a unit.
//   text_in  [0:127]      : plaintext or ciphertext toward the core
//   key      [0:32*Nk-1]  : cipher key toward the core
//   text_out [0:127]      : result from the core
// Modports: master (drives text/key, observes result), slave (the core side).
// ---------------------------------------------------------------------------
interface aes_cipher_core_if #(
  parameter int Nk = 4
);
  logic [0:127]      text_in;
  logic [0:32*Nk-1]  key;
  logic [0:127]      text_out;

  modport master (output text_in, output key, input text_out);
  modport slave  (input text_in, input key, output text_out);
endinterface

// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand
// Purely combinational FIPS-197 key schedule.
//   key        [0:32*Nk-1]       : cipher key, big-endian bytes
//   round_keys [0:128*(Nr+1)-1]  : w[0..4*(Nr+1)-1] concatenated; round key
//                                  r occupies bits 128r..128r+127
// Each word lives in its own generate scope so the chain w[i-1] -> w[i]
// is a plain feed-forward net rather than a self-referencing array.
// ---------------------------------------------------------------------------
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic [0:32*Nk-1]      key,
  output logic [0:128*(Nr+1)-1] round_keys
);

  localparam int NW = 4 * (Nr + 1);

  for (genvar i = 0; i < NW; i++) begin : g_w
    word_t w;
    if (i < Nk) begin : g_seed
      assign w = key[32*i +: 32];
    end else begin : g_next
      word_t temp;
      if (i % Nk == 0) begin : g_rot
        assign temp = sub_word(rot_word(g_w[i-1].w)) ^ {RCON[i/Nk - 1], 24'h000000};
      end else if (Nk > 6 && i % Nk == 4) begin : g_sub
        // AES-256 adds a SubWord halfway through each 8-word group.
        assign temp = sub_word(g_w[i-1].w);
      end else begin : g_pass
        assign temp = g_w[i-1].w;
      end
      assign w = g_w[i-Nk].w ^ temp;
    end
    assign round_keys[32*i +: 32] = w;
  end

endmodule

// File: rtl/aes_cipher_core.sv
// ---------------------------------------------------------------------------
// aes_cipher_core
// Free-running iterative AES-128/192/256, one round per clock. Each pass of
// Nr+2 cycles samples text_in/key at cnt=0, runs the initial AddRoundKey at
// cnt=1, full rounds at cnt=2..Nr and the final round into text_out at
// cnt=Nr+1. DECRYPT=1 runs the standard inverse cipher instead.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low
//   text_in  [0:127]     : plaintext (encrypt) / ciphertext (decrypt)
//   key      [0:32*Nk-1] : cipher key
//   text_out [0:127]     : registered result, updates only at cnt=Nr+1
// ---------------------------------------------------------------------------
module aes_cipher_core
  import aes_pkg::*;
#(
  parameter int Nk      = 4,
  parameter int Nr      = 10,
  parameter int DECRYPT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:127]      text_in,
  input  logic [0:32*Nk-1]  key,
  output logic [0:127]      text_out
);

  if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_params
    $fatal(1, "aes_cipher_core: illegal Nk/Nr combination");
  end

  localparam int          RKW      = $clog2(Nr + 1);
  localparam logic [3:0]  CNT_LAST = 4'(Nr + 1);

  logic [3:0]       cnt_q,      cnt_d;
  state_t           text_r_q,   text_r_d;
  logic [0:32*Nk-1] key_r_q,    key_r_d;
  state_t           state_q,    state_d;
  state_t           text_out_q, text_out_d;

  logic [0:128*(Nr+1)-1] round_keys;
  state_t                rk_arr [Nr+1];
  state_t                rk;
  logic [RKW-1:0]        rk_idx;
  phase_e                phase;
  state_t                enc_mid;
  state_t                dec_mid;

  aes_key_expand #(
    .Nk(Nk),
    .Nr(Nr)
  ) u_key_expand (
    .key        (key_r_q),
    .round_keys (round_keys)
  );

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign rk_arr[r] = round_keys[128*r +: 128];
  end

  // Decode the pass counter and pick the round key. Encrypt walks rk[0..Nr]
  // as cnt goes 1..Nr+1; decrypt walks the same keys in reverse.
  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
    rk_idx = '0;
    if (cnt_q == 4'd0)          phase = PH_LOAD;
    else if (cnt_q == 4'd1)     phase = PH_FIRST;
    else if (cnt_q == CNT_LAST) phase = PH_FINAL;
    else                        phase = PH_ROUND;
    if (phase != PH_LOAD) begin
      if (DECRYPT != 0) rk_idx = RKW'(Nr + 1 - int'(cnt_q));
      else              rk_idx = RKW'(int'(cnt_q) - 1);
    end
    rk = rk_arr[rk_idx];
  end

  // Round datapath. The final round is the full round minus (Inv)MixColumns,
  // so both share the substitute/shift half.
  always_comb begin
    enc_mid    = shift_rows(sub_bytes(state_q));
    dec_mid    = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk;
    text_r_d   = text_r_q;
    key_r_d    = key_r_q;
    state_d    = state_q;
    text_out_d = text_out_q;
    case (phase)
      PH_LOAD: begin
        text_r_d = text_in;
        key_r_d  = key;
      end
      PH_FIRST: state_d = text_r_q ^ rk;
      PH_ROUND: state_d = (DECRYPT != 0) ? inv_mix_columns(dec_mid) : (mix_columns(enc_mid) ^ rk);
      PH_FINAL: text_out_d = (DECRYPT != 0) ? dec_mid : (enc_mid ^ rk);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      text_r_q   <= '0;
      key_r_q    <= '0;
      state_q    <= '0;
      text_out_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      text_r_q   <= text_r_d;
      key_r_q    <= key_r_d;
      state_q    <= state_d;
      text_out_q <= text_out_d;
    end
  end

  assign text_out = text_out_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// ---------------------------------------------------------------------------
// tb_aes_cipher_core
// Directed known-answer bench for aes_cipher_core: AES-256 encrypt with a
// chained decrypt (driven through aes_cipher_core_if), plus AES-128 and
// AES-192 encrypt/decrypt pairs. m_cnt tracks the expected pass phase of
// the Nr=14 instances so stimulus can be placed at a known cnt.
// ---------------------------------------------------------------------------
module tb_aes_cipher_core;
  import aes_pkg::*;

  localparam logic [0:255] KEY256_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [0:127] PT_A     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] CT256_A  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [0:255] KEY256_B = 256'ha1b2c3d4e5f6a7b8c9d0e1f2a3b4c5d60708090a0b0c0d0e0f10111213141516;
  localparam logic [0:127] PT_B     = 128'h1234567890abcdef0123456789abcdef;
  localparam logic [0:127] CT256_B  = 128'h1a457798d81ded2b7b079d51ac3b88d7;
  localparam logic [0:127] CT256_Z  = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [0:127] KEY128   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] CT128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:191] KEY192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [0:127] CT192    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         clk;
  logic         reset;
  logic [0:127] dec256_out;
  logic [0:127] text128_in;
  logic [0:127] key128;
  logic [0:191] key192;
  logic [0:127] enc128_out, dec128_out;
  logic [0:127] enc192_out, dec192_out;
  int           m_cnt;
  int           n_vec;
  int           n_bad;

  aes_cipher_core_if #(.Nk(8)) enc_if ();

  aes_cipher_core #(.Nk(8), .Nr(14), .DECRYPT(0)) u_enc256 (
    .clk(clk), .reset(reset), .text_in(enc_if.text_in), .key(enc_if.key), .text_out(enc_if.text_out));
  aes_cipher_core #(.Nk(8), .Nr(14), .DECRYPT(1)) u_dec256 (
    .clk(clk), .reset(reset), .text_in(enc_if.text_out), .key(enc_if.key), .text_out(dec256_out));
  aes_cipher_core #(.Nk(4), .Nr(10), .DECRYPT(0)) u_enc128 (
    .clk(clk), .reset(reset), .text_in(text128_in), .key(key128), .text_out(enc128_out));
  aes_cipher_core #(.Nk(4), .Nr(10), .DECRYPT(1)) u_dec128 (
    .clk(clk), .reset(reset), .text_in(enc128_out), .key(key128), .text_out(dec128_out));
  aes_cipher_core #(.Nk(6), .Nr(12), .DECRYPT(0)) u_enc192 (
    .clk(clk), .reset(reset), .text_in(text128_in), .key(key192), .text_out(enc192_out));
  aes_cipher_core #(.Nk(6), .Nr(12), .DECRYPT(1)) u_dec192 (
    .clk(clk), .reset(reset), .text_in(enc192_out), .key(key192), .text_out(dec192_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected cnt of the AES-256 instances: 0 on the first edge after reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_cnt <= 0;
    else        m_cnt <= (m_cnt == 15) ? 0 : m_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wait_cycles(3);
    n_vec++;
    if (enc_if.text_out !== 128'h0) begin
      n_bad++; $display("[TB] FAIL reset_enc256: got %h expected %h", enc_if.text_out, 128'h0);
    end
    n_vec++;
    if (dec256_out !== 128'h0) begin
      n_bad++; $display("[TB] FAIL reset_dec256: got %h expected %h", dec256_out, 128'h0);
    end
    n_vec++;
    if (enc128_out !== 128'h0) begin
      n_bad++; $display("[TB] FAIL reset_enc128: got %h expected %h", enc128_out, 128'h0);
    end
    n_vec++;
    if (dec192_out !== 128'h0) begin
      n_bad++; $display("[TB] FAIL reset_dec192: got %h expected %h", dec192_out, 128'h0);
    end
    reset = 1'b1;
  endtask

  task automatic test_kat256(input string name, input logic [0:255] k,
                             input logic [0:127] pt, input logic [0:127] ct);
    enc_if.key     = k;
    enc_if.text_in = pt;
    wait_cycles(85);
    n_vec++;
    if (enc_if.text_out !== ct) begin
      n_bad++; $display("[TB] FAIL %s_enc: got %h expected %h", name, enc_if.text_out, ct);
    end
    n_vec++;
    if (dec256_out !== pt) begin
      n_bad++; $display("[TB] FAIL %s_dec: got %h expected %h", name, dec256_out, pt);
    end
  endtask

  task automatic test_aes128_192();
    wait_cycles(2);
    n_vec++;
    if (enc128_out !== CT128) begin
      n_bad++; $display("[TB] FAIL aes128_enc: got %h expected %h", enc128_out, CT128);
    end
    n_vec++;
    if (dec128_out !== PT_A) begin
      n_bad++; $display("[TB] FAIL aes128_dec: got %h expected %h", dec128_out, PT_A);
    end
    n_vec++;
    if (enc192_out !== CT192) begin
      n_bad++; $display("[TB] FAIL aes192_enc: got %h expected %h", enc192_out, CT192);
    end
    n_vec++;
    if (dec192_out !== PT_A) begin
      n_bad++; $display("[TB] FAIL aes192_dec: got %h expected %h", dec192_out, PT_A);
    end
  endtask

  // Garbage driven right after a sampling edge must never reach text_out.
  task automatic test_resample();
    int guard;
    guard = 0;
    while (m_cnt != 1 && guard < 40) begin
      @(negedge clk); guard++;
    end
    n_vec++;
    if (m_cnt != 1) begin
      n_bad++; $display("[TB] FAIL resample_align: got cnt %0d expected %0d", m_cnt, 1);
    end
    enc_if.key     = ~KEY256_B;
    enc_if.text_in = ~PT_B;
    guard = 0;
    do begin
      @(negedge clk); guard++;
    end while (m_cnt != 0 && guard < 40);
    n_vec++;
    if (enc_if.text_out !== CT256_B) begin
      n_bad++; $display("[TB] FAIL resample_midpass: got %h expected %h", enc_if.text_out, CT256_B);
    end
    enc_if.key     = KEY256_B;
    enc_if.text_in = PT_B;
    wait_cycles(40);
    n_vec++;
    if (enc_if.text_out !== CT256_B) begin
      n_bad++; $display("[TB] FAIL resample_after: got %h expected %h", enc_if.text_out, CT256_B);
    end
  endtask

  task automatic test_reset_midpass();
    int guard;
    guard = 0;
    while (m_cnt != 7 && guard < 40) begin
      @(negedge clk); guard++;
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (enc_if.text_out !== 128'h0) begin
      n_bad++; $display("[TB] FAIL midreset_enc256: got %h expected %h", enc_if.text_out, 128'h0);
    end
    n_vec++;
    if (enc128_out !== 128'h0) begin
      n_bad++; $display("[TB] FAIL midreset_enc128: got %h expected %h", enc128_out, 128'h0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_cycles(15);
    n_vec++;
    if (enc_if.text_out !== 128'h0) begin
      n_bad++; $display("[TB] FAIL midreset_hold: got %h expected %h", enc_if.text_out, 128'h0);
    end
    wait_cycles(1);
    n_vec++;
    if (enc_if.text_out !== CT256_A) begin
      n_bad++; $display("[TB] FAIL midreset_first: got %h expected %h", enc_if.text_out, CT256_A);
    end
    wait_cycles(85);
    n_vec++;
    if (dec256_out !== PT_A) begin
      n_bad++; $display("[TB] FAIL midreset_dec256: got %h expected %h", dec256_out, PT_A);
    end
    n_vec++;
    if (enc128_out !== CT128) begin
      n_bad++; $display("[TB] FAIL midreset_enc128: got %h expected %h", enc128_out, CT128);
    end
  endtask

  task automatic test_stability();
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      n_vec++;
      if (enc_if.text_out !== CT256_A) begin
        n_bad++; $display("[TB] FAIL stable_enc cycle %0d: got %h expected %h", i, enc_if.text_out, CT256_A);
      end
      n_vec++;
      if (dec256_out !== PT_A) begin
        n_bad++; $display("[TB] FAIL stable_dec cycle %0d: got %h expected %h", i, dec256_out, PT_A);
      end
    end
  endtask

  initial begin
    n_vec          = 0;
    n_bad          = 0;
    reset          = 1'b0;
    enc_if.key     = KEY256_A;
    enc_if.text_in = PT_A;
    text128_in     = PT_A;
    key128         = KEY128;
    key192         = KEY192;
    test_reset();
    test_kat256("kat256_a", KEY256_A, PT_A, CT256_A);
    test_aes128_192();
    test_kat256("kat256_b", KEY256_B, PT_B, CT256_B);
    test_resample();
    test_kat256("kat256_zero", 256'h0, 128'h0, CT256_Z);
    test_kat256("kat256_a_again", KEY256_A, PT_A, CT256_A);
    test_reset_midpass();
    test_stability();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_cipher_core.md
Name: aes_cipher_core

Overview:
- Iterative AES-128/192/256 block-cipher core (FIPS-197), one round per clock.
- DECRYPT selects the direction, so the same RTL serves as the encryptor and the decryptor.
- Free-running: continuously re-samples its plaintext/ciphertext and key inputs and republishes the result every pass; no handshake.
- Sits in the crypto datapath; a decrypt instance may be chained directly on an encrypt instance's output.

Parameters:
- Nk, 4, key length in 32-bit words. Legal values: 4, 6, 8.
- Nr, 10, number of rounds. Must be 10/12/14 matching Nk=4/6/8; illegal combos are a $fatal at elaboration.
- DECRYPT, 0, 0 = cipher (encrypt), 1 = inverse cipher (decrypt).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- text_in  input  [0:127]  plaintext (encrypt) or ciphertext (decrypt). Bit 0 is the MSB; bits 0..7 are FIPS byte 0.
- key  input  [0:32*Nk-1]  cipher key, same big-endian byte order.
- text_out  output  [0:127]  ciphertext (encrypt) or plaintext (decrypt); registered.

Behaviour:
- Pass counter cnt runs 0..Nr+1, then wraps to 0. One pass is Nr+2 cycles (16 cycles for AES-256).
- cnt=0:
  - text_r <= text_in; key_r <= key (input sampling point).
  - Inputs changing at any other time have no effect until the next cnt=0.
- Key schedule: combinational from key_r, producing 4*(Nr+1) words w[i] per FIPS-197 (RotWord, SubWord, Rcon; extra SubWord when Nk>6 and i mod Nk == 4). Round key rk[r] = w[4r..4r+3].
- Encrypt (DECRYPT=0):
  - cnt=1: state <= text_r ^ rk[0].
  - cnt=2..Nr: state <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), rk[cnt-1]).
  - cnt=Nr+1: text_out <= SubBytes, ShiftRows, AddRoundKey rk[Nr] (no MixColumns).
- Decrypt (DECRYPT=1), standard inverse cipher:
  - cnt=1: state <= text_r ^ rk[Nr].
  - cnt=2..Nr: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[Nr-cnt+1])).
  - cnt=Nr+1: text_out <= InvShiftRows, InvSubBytes, AddRoundKey rk[0].
- text_out holds its value between updates; it changes only at cnt=Nr+1.
- Latency: output reflects inputs stable for at most 2*(Nr+2) cycles.
  - Chained enc->dec settles within 3*(Nr+2) cycles (48 cycles for AES-256). Benches wait >= 85 cycles.
- Column/byte layout: state byte k = bits 8k..8k+7, column c = bytes 4c..4c+3 (FIPS column-major input mapping).
- GF(2^8) arithmetic uses polynomial 0x11B. MixColumns is {02,03,01,01}; InvMixColumns is {0e,0b,0d,09}.
- Reset asserted (async, any time, including mid-pass):
  - text_out = 0, state = 0, text_r = 0, key_r = 0, cnt = 0.
  - After release, a new pass starts at cnt=0 on the first rising edge.
- No X propagation: every register has a reset value.

Decomposition:
- Package aes_pkg:
  - Constants: sbox and inv_sbox byte arrays, rcon array.
  - Functions: xtime, gmul, sub_word, rot_word, shift_rows/inv_shift_rows, mix_columns/inv_mix_columns on a 128-bit state.
  - Typedefs: state_t [0:127] and word_t [0:31].
- One sub-module: aes_key_expand (params Nk, Nr; input key [0:32*Nk-1]; output all round keys [0:128*(Nr+1)-1]), purely combinational.
- Round datapath stays in aes_cipher_core.

Test Plan:
- AES-256 known answer. Key 000102..1e1f, text_in 00112233445566778899aabbccddeeff. After 85 cycles, encrypt text_out = 8ea2b7ca516745bfeafc49904b496089; a chained decrypt returns the plaintext.
- AES-256 second vector. Key a1b2c3d4e5f6a7b8c9d0e1f2a3b4c5d60708090a0b0c0d0e0f10111213141516, text_in 1234567890abcdef0123456789abcdef. Encrypt = 1a457798d81ded2b7b079d51ac3b88d7; chained decrypt = text_in. Inputs are changed mid-pass to check the re-sampling.
- AES-256 all-zero key and all-zero text -> dc95c078a2408989ad48a21492842087; decrypt -> all zeros.
- AES-128 (Nk=4, Nr=10). Key 000102..0f, text 00112233..ff -> 69c4e0d86a7b0430d8cdb78070b4c55a. AES-192 (Nk=6, Nr=12), key 000102..17 -> dda97ca4864cdfe06eaf70a0ec0d7191. Both decrypt back to the plaintext.
- Reset: assert reset=0 mid-pass (cnt around 7). text_out goes to 0 immediately, asynchronously. After release, the correct ciphertext appears within 2*(Nr+2) cycles.
- Stability: hold inputs constant for 10 passes; text_out never glitches and changes only at cnt=Nr+1.
